// File: rtl/freq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : freq_pkg
//  Description : Shared types and constants for the frequency accumulator:
//                the controller state encoding and the operating-mode codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package freq_pkg;

  // Controller states, explicitly 3 bits wide
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  // Operating modes selected by the MODE parameter of freq_accum
  localparam int MODE_SUM    = 0;  // one pass over the ROM, report the total
  localparam int MODE_REPEAT = 1;  // loop over the ROM until a running sum repeats

endpackage : freq_pkg
`default_nettype wire

// File: rtl/seen_bitmap.sv
`default_nettype none
// ============================================================================
//  Module      : seen_bitmap
//  Description : 2^AW x 1 bit memory recording which running sums have been
//                observed. Combinational test port, synchronous write port
//                used both to clear entries and to mark new sums.
//  Revision    : 1.0 - initial release
// ============================================================================
module seen_bitmap #(
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic [AW-1:0] test_addr,
  output logic          test_hit,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_val
);

  // No reset: the owner sweeps every entry before the bitmap is consulted
  logic r_mem [0:(1<<AW)-1];

  assign test_hit = r_mem[test_addr];

  // Single write port: clear sweep or mark-as-seen
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_val;
    end
  end

endmodule : seen_bitmap
`default_nettype wire

// File: rtl/freq_accum.sv
`default_nettype none
// ============================================================================
//  Module      : freq_accum
//  Description : Streams signed words from an external combinational ROM and
//                accumulates them. MODE_SUM reports the total of one pass;
//                MODE_REPEAT cycles through the ROM and reports the first
//                running sum that occurs twice, tracked in a seen-bitmap.
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_accum
  import freq_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 16,
  parameter int N_ENTRIES  = 973,
  parameter int MODE       = 0,
  parameter int SEEN_AW    = 18,
  parameter int MAX_PASSES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic signed [DATA_W-1:0] rom_data,
  output logic signed [DATA_W-1:0] result,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  // Pass counter must be able to hold MAX_PASSES itself for the limit compare
  localparam int PASS_W = $clog2(MAX_PASSES + 1);
  // Range check is done one bit wider than both the data and bitmap domains
  localparam int EXT_W  = ((DATA_W > SEEN_AW) ? DATA_W : SEEN_AW) + 1;

  localparam logic [ADDR_W-1:0] c_LAST_IDX    = ADDR_W'(N_ENTRIES - 1);
  localparam logic [EXT_W-1:0]  c_SEEN_OFFSET = EXT_W'(1) << (SEEN_AW - 1);
  localparam logic [PASS_W-1:0] c_PASS_LIMIT  = PASS_W'(MAX_PASSES);
  localparam bit                c_REPEAT      = (MODE == MODE_REPEAT);

  state_t                     r_state;
  state_t                     w_state_next;
  logic signed [DATA_W-1:0]   r_sum;
  logic signed [DATA_W-1:0]   r_result;
  logic signed [DATA_W-1:0]   w_new;
  logic [ADDR_W-1:0]          r_idx;
  logic [PASS_W-1:0]          r_pass;
  logic [PASS_W-1:0]          w_pass_next;
  logic [SEEN_AW:0]           r_clr;      // MSB set => sweep finished
  logic [EXT_W-1:0]           w_new_ext;
  logic [EXT_W-1:0]           w_off;
  logic [SEEN_AW-1:0]         w_seen_addr;
  logic                       w_in_range;
  logic                       w_seen_hit;
  logic                       w_last;
  logic                       w_pass_limit;
  logic                       w_clr_done;
  logic                       w_bm_we;
  logic [SEEN_AW-1:0]         w_bm_addr;
  logic                       w_bm_val;

  // Candidate sum, wrapping naturally at DATA_W
  assign w_new       = r_sum + rom_data;

  // Bias the sum so the covered signed range maps onto bitmap index 0..2^AW-1;
  // any bit set above the bitmap index means the sum falls outside the range
  assign w_new_ext   = {{(EXT_W-DATA_W){w_new[DATA_W-1]}}, w_new};
  assign w_off       = w_new_ext + c_SEEN_OFFSET;
  assign w_seen_addr = w_off[SEEN_AW-1:0];
  assign w_in_range  = (w_off[EXT_W-1:SEEN_AW] == '0);

  assign w_last       = (r_idx == c_LAST_IDX);
  assign w_pass_next  = r_pass + PASS_W'(1);
  assign w_pass_limit = w_last && (w_pass_next == c_PASS_LIMIT);
  assign w_clr_done   = r_clr[SEEN_AW];

  assign rom_addr = r_idx;
  assign result   = r_result;

  seen_bitmap #(
    .AW (SEEN_AW)
  ) u_seen (
    .clk       (clk),
    .test_addr (w_seen_addr),
    .test_hit  (w_seen_hit),
    .wr_en     (w_bm_we),
    .wr_addr   (w_bm_addr),
    .wr_val    (w_bm_val)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; in repeat mode a range error beats everything, and a
  // repeated sum beats the pass limit when both land on the same cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          w_state_next = c_REPEAT ? ST_CLEAR : ST_RUN;
        end
      end
      ST_CLEAR: begin
        if (w_clr_done) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (c_REPEAT) begin
          if (!w_in_range) begin
            w_state_next = ST_ERROR;
          end else if (w_seen_hit) begin
            w_state_next = ST_DONE;
          end else if (w_pass_limit) begin
            w_state_next = ST_ERROR;
          end
        end else if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Status outputs and bitmap write port, decoded from the current state
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    w_bm_we   = 1'b0;
    w_bm_addr = w_seen_addr;
    w_bm_val  = 1'b1;
    case (r_state)
      ST_CLEAR: begin
        busy    = 1'b1;
        w_bm_we = 1'b1;
        if (w_clr_done) begin
          // Sweep finished: the starting sum of zero counts as already seen
          w_bm_addr = c_SEEN_OFFSET[SEEN_AW-1:0];
          w_bm_val  = 1'b1;
        end else begin
          w_bm_addr = r_clr[SEEN_AW-1:0];
          w_bm_val  = 1'b0;
        end
      end
      ST_RUN: begin
        busy    = 1'b1;
        w_bm_we = c_REPEAT && w_in_range && !w_seen_hit;
      end
      ST_DONE:  done = 1'b1;
      ST_ERROR: err  = 1'b1;
      default: ;
    endcase
  end

  // Datapath: sum, ROM index, pass count, clear sweep pointer and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum    <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_pass   <= '0;
      r_clr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            r_sum  <= '0;
            r_idx  <= '0;
            r_pass <= '0;
            r_clr  <= '0;
          end
        end
        ST_CLEAR: begin
          if (!w_clr_done) begin
            r_clr <= r_clr + (SEEN_AW+1)'(1);
          end
        end
        ST_RUN: begin
          r_sum <= w_new;
          // Capture the sum on whichever cycle ends the run (done or error)
          if (w_state_next != ST_RUN) begin
            r_result <= w_new;
          end
          if (w_last) begin
            r_idx  <= '0;
            r_pass <= w_pass_next;
          end else begin
            r_idx  <= r_idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule : freq_accum
`default_nettype wire
